// File: rtl/simple_cpu.sv
// -----------------------------------------------------------------------------
// simple_cpu
//
// Minimal multi-cycle 8-bit CPU core. It has a 4-entry register file, a
// 32-word data memory and a two-operation ALU. There is no program counter.
// The core executes the 20-bit word on `instruction` and fetches it again at
// the start of every instruction cycle.
//
// Every instruction takes exactly three clocks:
//   S_FETCH : latch the word into ir and read regfile[X1], [X2] and [X3]
//             into the operand registers.
//   S_EXEC  : compute the ALU result and the memory address. Both are
//             computed for every instruction type; only S_WB decides which
//             one is used.
//   S_WB    : perform at most one write, to regfile (ALU / LOAD_R) or to
//             data_mem (STORE_R).
//
// Encoding:
//   [19:18] type   00 NOP, 01 ALU, 10 LOAD_R, 11 STORE_R
//   [17:16] X1     destination register, or store-data register
//   [15:14] X2     ALU source A, or address base register
//   [13:12] X3     ALU source B
//   [11:4]  OFFSET 8-bit unsigned address offset
//   [3:0]   ALU opcode: 0 ADD, 1 SUB
//
// Configuration macro: SIMPLE_CPU_EXT_ALU_EN
//   When defined, the core adds ALU opcodes 2 AND, 3 OR, 4 XOR and
//   5 pass-through of regfile[X2].
//   When undefined, only opcodes 0 and 1 write; opcodes 2..15 act as NOP.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst          in   1   asynchronous, active-high reset
//   instruction  in   20  instruction word, held stable by the driver
//   state_dbg    out  2   current FSM state (S_FETCH=0, S_EXEC=1, S_WB=2)
//   ir_dbg       out  20  latched instruction register
//
// Architectural state lives in the arrays `regfile` and `data_mem`.
// -----------------------------------------------------------------------------
module simple_cpu #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_BITS   = 5,
  parameter int INSTR_WIDTH = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] instruction,
  output logic [1:0]             state_dbg,
  output logic [INSTR_WIDTH-1:0] ir_dbg
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_WB    = 2'd2;

  localparam logic [1:0] T_NOP   = 2'b00;
  localparam logic [1:0] T_ALU   = 2'b01;
  localparam logic [1:0] T_LOAD  = 2'b10;
  localparam logic [1:0] T_STORE = 2'b11;

  localparam int MEM_WORDS = 2 ** ADDR_BITS;

  // Architectural state
  logic [DATA_WIDTH-1:0] regfile  [0:3];
  logic [DATA_WIDTH-1:0] data_mem [0:MEM_WORDS-1];

  // Pipeline / control registers
  logic [1:0]             state_q,  state_d;
  logic [INSTR_WIDTH-1:0] ir_q,     ir_d;
  logic [DATA_WIDTH-1:0]  op_a_q,   op_a_d;    // regfile[X1], the store data
  logic [DATA_WIDTH-1:0]  op_b_q,   op_b_d;    // regfile[X2]
  logic [DATA_WIDTH-1:0]  op_c_q,   op_c_d;    // regfile[X3]
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic [ADDR_BITS-1:0]   addr_q,   addr_d;

  // Combinational helpers
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  alu_ok;
  logic                  reg_we;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] reg_wdata;

  // ALU. It decodes from ir_q, so the same opcode drives the computation in
  // S_EXEC and the write-enable decision in S_WB.
  always_comb begin
    alu_out = '0;
    alu_ok  = 1'b0;
    case (ir_q[3:0])
      4'd0: begin alu_out = op_b_q + op_c_q; alu_ok = 1'b1; end
      4'd1: begin alu_out = op_b_q - op_c_q; alu_ok = 1'b1; end
`ifdef SIMPLE_CPU_EXT_ALU_EN
      4'd2: begin alu_out = op_b_q & op_c_q; alu_ok = 1'b1; end
      4'd3: begin alu_out = op_b_q | op_c_q; alu_ok = 1'b1; end
      4'd4: begin alu_out = op_b_q ^ op_c_q; alu_ok = 1'b1; end
      4'd5: begin alu_out = op_b_q;          alu_ok = 1'b1; end
`endif
      default: begin alu_out = '0; alu_ok = 1'b0; end
    endcase
  end

  // FSM next-state and datapath
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_c_d    = op_c_q;
    result_d  = result_q;
    addr_d    = addr_q;
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    reg_wdata = result_q;

    case (state_q)
      S_FETCH: begin
        // Operands come from the live word on this same edge. A write to X1
        // in S_WB therefore can never affect this instruction's own sources.
        ir_d    = instruction;
        op_a_d  = regfile[instruction[17:16]];
        op_b_d  = regfile[instruction[15:14]];
        op_c_d  = regfile[instruction[13:12]];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        result_d = alu_out;
        // 8-bit base + offset. Only the low ADDR_BITS are kept, so the
        // address wraps around silently.
        addr_d   = ADDR_BITS'(op_b_q + ir_q[11:4]);
        state_d  = S_WB;
      end
      S_WB: begin
        case (ir_q[19:18])
          T_ALU:   reg_we = alu_ok;
          T_LOAD: begin
            reg_we    = 1'b1;
            reg_wdata = data_mem[addr_q];
          end
          T_STORE: mem_we = 1'b1;
          T_NOP:   reg_we = 1'b0;
          default: reg_we = 1'b0;
        endcase
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset is asynchronous. It drops any in-flight write because writes only
  // happen on the clock edge that leaves S_WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      ir_q     <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_c_q   <= '0;
      result_q <= '0;
      addr_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        regfile[i] <= DATA_WIDTH'(i);
      end
      for (int i = 0; i < MEM_WORDS; i++) begin
        data_mem[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_c_q   <= op_c_d;
      result_q <= result_d;
      addr_q   <= addr_d;
      if (reg_we) begin
        regfile[ir_q[17:16]] <= reg_wdata;
      end
      if (mem_we) begin
        data_mem[addr_q] <= op_a_q;
      end
    end
  end

  assign state_dbg = state_q;
  assign ir_dbg    = ir_q;

endmodule

// File: tb/tb_simple_cpu.sv
// -----------------------------------------------------------------------------
// tb_simple_cpu
//
// Directed testbench for simple_cpu.
//
// The driver issues one instruction per instruction cycle. It changes the
// word on the falling edge plus 1 time unit whenever the core is in S_FETCH,
// and pushes the hand-computed expected write for that instruction into
// exp_q.
//
// The monitor watches for S_WB -> S_FETCH, which marks instruction
// completion. On each completion it pops an expected entry, checks that the
// three states before it were FETCH, EXEC, WB, and checks the written
// location. Completions of idle NOPs that the driver did not track are
// ignored; a missing completion shows up as a drain timeout.
//
// Full-state snapshots (all registers and all memory words) are compared
// against hand-set expected arrays at chosen points.
// -----------------------------------------------------------------------------
module tb_simple_cpu;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_WB    = 2'd2;

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_REG  = 2'd1;
  localparam logic [1:0] K_MEM  = 2'd2;

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] instruction = '0;
  logic [1:0]  state_dbg;
  logic [19:0] ir_dbg;

  always #5 clk = ~clk;

  simple_cpu dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .state_dbg   (state_dbg),
    .ir_dbg      (ir_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  // Each entry is {kind[1:0], addr[4:0], data[7:0]}.
  logic [14:0] exp_q[$];
  logic [7:0]  exp_rf  [4];
  logic [7:0]  exp_mem [32];
  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [14:0] mk(input logic [1:0] kind,
                                     input logic [4:0] addr,
                                     input logic [7:0] data);
    return {kind, addr, data};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin : monitor
    logic [1:0]  s1, s2, s3;
    logic [14:0] e;
    s1 = 2'd3;
    s2 = 2'd3;
    s3 = 2'd3;
    forever begin
      @(negedge clk);
      if (!rst && s1 == S_WB && state_dbg == S_FETCH && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state_seq", {28'd0, s3, s2}, {28'd0, S_FETCH, S_EXEC});
        if (e[14:13] == K_REG) begin
          chk($sformatf("reg_wr r%0d", e[9:8]), dut.regfile[e[9:8]], e[7:0]);
        end else if (e[14:13] == K_MEM) begin
          chk($sformatf("mem_wr m%0d", e[12:8]), dut.data_mem[e[12:8]], e[7:0]);
        end
      end
      s3 = s2;
      s2 = s1;
      s1 = state_dbg;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic wait_fetch();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (state_dbg != S_FETCH && n < 8);
    if (state_dbg != S_FETCH) fail_now("wait_fetch");
  endtask

  task automatic issue(input logic [19:0] instr, input logic [14:0] exp);
    wait_fetch();
    #1;
    instruction = instr;
    exp_q.push_back(exp);
  endtask

  // Changes the word while the core is in S_EXEC; the change must not affect
  // the instruction already latched in ir.
  task automatic issue_glitch(input logic [19:0] instr, input logic [14:0] exp,
                              input logic [19:0] glitch);
    issue(instr, exp);
    @(negedge clk);
    #1;
    instruction = glitch;
  endtask

  task automatic drain();
    int n = 0;
    issue(20'h00000, mk(K_NONE, 5'd0, 8'd0));
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      fail_now("drain");
      exp_q.delete();
    end
  endtask

  task automatic set_reset_model();
    for (int i = 0; i < 4; i++) exp_rf[i] = 8'(i);
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'h00;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s r%0d", tag, i), dut.regfile[i], exp_rf[i]);
    end
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("%s m%0d", tag, i), dut.data_mem[i], exp_mem[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    instruction = 20'h00000;
    @(negedge clk);
    chk("rst_state", state_dbg, S_FETCH);
    chk("rst_ir", ir_dbg, 0);
    set_reset_model();
    check_all("rst");
    #1;
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stim
    rst = 1'b1;
    instruction = 20'h00000;
    repeat (2) @(negedge clk);
    chk("init_state", state_dbg, S_FETCH);
    chk("init_ir", ir_dbg, 0);
    set_reset_model();
    check_all("init");
    #1;
    rst = 1'b0;

    // Idle NOP: no writes
    issue(20'h00000, mk(K_NONE, 5'd0, 8'd0));
    drain();
    check_all("idle");

    // ALU sequence. The ADD is held for two executions; it is idempotent.
    issue(20'h47000, mk(K_REG, 5'd0, 8'd4));
    issue(20'h47000, mk(K_REG, 5'd0, 8'd4));
    issue_glitch(20'h53000, mk(K_REG, 5'd1, 8'd7), 20'h00000);
    issue(20'h72001, mk(K_REG, 5'd3, 8'd2));
    // Stores and loads
    issue(20'hD80F0, mk(K_MEM, 5'd17, 8'd7));
    issue(20'hCC160, mk(K_MEM, 5'd24, 8'd4));
    issue(20'hB80F0, mk(K_REG, 5'd3, 8'd7));
    issue(20'hB8160, mk(K_REG, 5'd3, 8'd4));
    // ALU opcode 15 is undefined: no write
    issue(20'h4700F, mk(K_NONE, 5'd0, 8'd0));
    drain();
    exp_rf[0] = 8'd4;
    exp_rf[1] = 8'd7;
    exp_rf[2] = 8'd2;
    exp_rf[3] = 8'd4;
    exp_mem[17] = 8'd7;
    exp_mem[24] = 8'd4;
    check_all("seq");

    // Wrap: r0 = 0 - 1 = 0xFF, then mem[(0xFF+2)&31 = 1] = r1 = 1
    do_reset();
    issue(20'h41001, mk(K_REG, 5'd0, 8'hFF));
    issue(20'hD0020, mk(K_MEM, 5'd1, 8'd1));
    drain();
    exp_rf[0] = 8'hFF;
    exp_mem[1] = 8'd1;
    check_all("wrap");

    // Reset during S_EXEC of an ADD: no write, then restart from S_FETCH
    do_reset();
    wait_fetch();
    #1;
    instruction = 20'h47000;
    @(negedge clk);
    chk("mid_pre_state", state_dbg, S_EXEC);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_state", state_dbg, S_FETCH);
    @(negedge clk);
    set_reset_model();
    check_all("mid_rst");
    #1;
    exp_q.push_back(mk(K_REG, 5'd0, 8'd4));
    rst = 1'b0;
    drain();
    exp_rf[0] = 8'd4;
    check_all("restart");

    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
